// File: rtl/cube_pkg.sv
// Shared types and defaults for the isometric cube rasteriser.
package cube_pkg;

    localparam int unsigned CUBE_X_W = 11;
    localparam int unsigned CUBE_Y_W = 10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEP   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    localparam int unsigned TOP_UR = 0;
    localparam int unsigned TOP_UL = 1;
    localparam int unsigned TOP_LR = 2;
    localparam int unsigned TOP_LL = 3;

endpackage

// File: rtl/cube_slope_dda.sv
// Incremental slope s(d)=floor(d*XDIAG/YDIAG), one row per step pulse, saturating at XDIAG.
module cube_slope_dda
    import cube_pkg::*;
#(
    parameter int unsigned      X_W   = CUBE_X_W,
    parameter int unsigned      Y_W   = CUBE_Y_W,
    parameter logic [X_W-1:0]   XDIAG = X_W'(50),
    parameter logic [Y_W-1:0]   YDIAG = Y_W'(90)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    output logic [X_W-1:0]   s,
    output logic             busy
);

    localparam int unsigned E_W = X_W + 1;

    logic [E_W-1:0] err;
    logic           sat_c;

    assign sat_c = (s == XDIAG);
    assign busy  = (err >= E_W'(YDIAG)) && !sat_c;

    // Accumulate XDIAG per row, then retire one YDIAG per cycle until err < YDIAG.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            s   <= '0;
            err <= '0;
        end else if (step && !sat_c) begin
            err <= err + E_W'(XDIAG);
        end else if (busy) begin
            err <= err - E_W'(YDIAG);
            s   <= s + X_W'(1);
        end
    end

endmodule

// File: rtl/cube_face_raster.sv
// Per-pixel face membership for one isometric cube at a frame-latched offset.
// Optional QBERT_HIT_EN adds a landing hit detector toggling cube_state.
module cube_face_raster
    import cube_pkg::*;
#(
    parameter int unsigned      X_W   = CUBE_X_W,
    parameter int unsigned      Y_W   = CUBE_Y_W,
    parameter logic [X_W-1:0]   XDIAG = X_W'(50),
    parameter logic [Y_W-1:0]   YDIAG = Y_W'(90),
    parameter logic [Y_W-1:0]   YLEN  = Y_W'(120)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [X_W-1:0]   x_cnt,
    input  logic [Y_W-1:0]   y_cnt,
    input  logic [X_W-1:0]   x_offset,
    input  logic [Y_W-1:0]   y_offset,
    output logic [3:0]       top_face,
    output logic             left_face,
    output logic             right_face
`ifdef QBERT_HIT_EN
    ,
    input  logic [X_W-1:0]   qbert_x,
    input  logic [Y_W-1:0]   qbert_y,
    input  logic             qbert_land,
    output logic             cube_state
`endif
);

    localparam int unsigned D_W = Y_W + 3;
    localparam int unsigned C_W = X_W + 3;

    localparam logic signed [D_W-1:0] D_ZERO  = '0;
    localparam logic signed [D_W-1:0] DY_TOP  = D_W'(YDIAG);
    localparam logic signed [D_W-1:0] DY_LOW  = D_W'(2 * int'(YDIAG));
    localparam logic signed [D_W-1:0] DY_BOT  = D_W'(2 * int'(YDIAG) + int'(YLEN));
    localparam logic signed [D_W-1:0] DY_LEN  = D_W'(YLEN);
    localparam logic signed [C_W-1:0] X_ONE   = C_W'(1);
    localparam logic signed [C_W-1:0] X_DIAG  = C_W'(XDIAG);

    state_t         state, state_d;
    logic [X_W-1:0] xo, xo_nxt_c;
    logic [Y_W-1:0] yo, yo_nxt_c, y_prev;
    logic           go_step_c, frame_start_c, active_c;

    logic [2:0]     dda_clear_c, dda_step_c, dda_busy;
    logic [X_W-1:0] s_a, s_b, s_c;

    // FSM next state: re-step the DDAs whenever the scanline changes.
    always_comb begin
        state_d   = state;
        go_step_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (y_cnt == '0) begin
                    go_step_c = 1'b1;
                    state_d   = S_STEP;
                end
            end
            S_STEP: begin
                if (!(|dda_busy)) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (y_cnt != y_prev) begin
                    go_step_c = 1'b1;
                    state_d   = S_STEP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign frame_start_c = go_step_c && (y_cnt == '0);
    assign xo_nxt_c      = frame_start_c ? x_offset : xo;
    assign yo_nxt_c      = frame_start_c ? y_offset : yo;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            xo     <= '0;
            yo     <= '0;
            y_prev <= '0;
        end else begin
            state <= state_d;
            xo    <= xo_nxt_c;
            yo    <= yo_nxt_c;
            if (go_step_c) y_prev <= y_cnt;
        end
    end

    // Row distances for the upcoming scanline; non-positive rows reset their DDA.
    logic signed [D_W-1:0] da_n_c, db_n_c, dc_n_c;
    assign da_n_c = $signed(D_W'(y_cnt)) - $signed(D_W'(yo_nxt_c));
    assign db_n_c = da_n_c - DY_TOP;
    assign dc_n_c = db_n_c - DY_LEN;

    always_comb begin
        dda_clear_c = '0;
        dda_step_c  = '0;
        if (go_step_c) begin
            dda_clear_c = {dc_n_c <= D_ZERO, db_n_c <= D_ZERO, da_n_c <= D_ZERO};
            dda_step_c  = ~dda_clear_c;
        end
    end

    cube_slope_dda #(.X_W(X_W), .Y_W(Y_W), .XDIAG(XDIAG), .YDIAG(YDIAG)) u_dda_a (
        .clk(clk), .reset(reset), .clear(dda_clear_c[0]), .step(dda_step_c[0]),
        .s(s_a), .busy(dda_busy[0])
    );
    cube_slope_dda #(.X_W(X_W), .Y_W(Y_W), .XDIAG(XDIAG), .YDIAG(YDIAG)) u_dda_b (
        .clk(clk), .reset(reset), .clear(dda_clear_c[1]), .step(dda_step_c[1]),
        .s(s_b), .busy(dda_busy[1])
    );
    cube_slope_dda #(.X_W(X_W), .Y_W(Y_W), .XDIAG(XDIAG), .YDIAG(YDIAG)) u_dda_c (
        .clk(clk), .reset(reset), .clear(dda_clear_c[2]), .step(dda_step_c[2]),
        .s(s_c), .busy(dda_busy[2])
    );

    // Span tests in signed space so off-screen bounds never wrap.
    logic signed [D_W-1:0] dy_c;
    logic signed [C_W-1:0] xs_c, xos_c, sa_c, sb_c, sc_c, hw_c, left_hi_c;
    logic                  in_up_c, in_up_open_c, in_low_c, in_side_c;
    logic [3:0]            top_c;
    logic                  left_c, right_c;

    always_comb begin
        dy_c         = $signed(D_W'(y_cnt)) - $signed(D_W'(yo));
        xs_c         = $signed(C_W'(x_cnt));
        xos_c        = $signed(C_W'(xo));
        sa_c         = $signed(C_W'(s_a));
        sb_c         = $signed(C_W'(s_b));
        sc_c         = $signed(C_W'(s_c));
        hw_c         = (dy_c <= DY_TOP) ? sa_c : X_DIAG - sb_c;
        in_up_c      = (dy_c >= D_ZERO) && (dy_c <= DY_TOP);
        in_up_open_c = (dy_c >  D_ZERO) && (dy_c <= DY_TOP);
        in_low_c     = (dy_c >= DY_TOP) && (dy_c <= DY_LOW);
        in_side_c    = (dy_c >= DY_TOP) && (dy_c <= DY_BOT);
        left_hi_c    = ((xos_c - X_DIAG + sb_c) < (xos_c - X_ONE)) ?
                       (xos_c - X_DIAG + sb_c) : (xos_c - X_ONE);

        top_c         = '0;
        top_c[TOP_UR] = in_up_c      && (xs_c >= xos_c) && (xs_c <= xos_c + hw_c);
        top_c[TOP_UL] = in_up_open_c && (xs_c >= xos_c - hw_c) && (xs_c < xos_c);
        top_c[TOP_LR] = in_low_c     && (xs_c >= xos_c) && (xs_c <= xos_c + hw_c);
        top_c[TOP_LL] = in_low_c     && (xs_c >= xos_c - hw_c) && (xs_c <= xos_c);

        left_c  = in_side_c && (xs_c >= xos_c - X_DIAG + sc_c) && (xs_c <= left_hi_c);
        right_c = in_side_c && (xs_c >= xos_c + X_DIAG - sb_c) && (xs_c <= xos_c + X_DIAG - sc_c);
    end

    assign active_c = (state == S_ACTIVE) && !go_step_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            top_face   <= '0;
            left_face  <= 1'b0;
            right_face <= 1'b0;
        end else begin
            top_face   <= active_c ? top_c : 4'b0000;
            left_face  <= active_c && left_c  && !(|top_c);
            right_face <= active_c && right_c && !(|top_c);
        end
    end

`ifdef QBERT_HIT_EN
    // Landing zone uses the offset in effect after any same-cycle frame latch.
    logic signed [C_W-1:0] qdx_c;
    logic signed [D_W-1:0] qy_c, qyo_c;
    logic                  hit_c;

    always_comb begin
        qdx_c = $signed(C_W'(qbert_x)) - $signed(C_W'(xo_nxt_c));
        qy_c  = $signed(D_W'(qbert_y));
        qyo_c = $signed(D_W'(yo_nxt_c));
        hit_c = qbert_land && (qdx_c > -X_DIAG) && (qdx_c < X_DIAG) &&
                (qy_c > qyo_c) && (qy_c < qyo_c + DY_LOW);
    end

    always_ff @(posedge clk) begin
        if (reset)      cube_state <= 1'b0;
        else if (hit_c) cube_state <= ~cube_state;
    end
`endif

endmodule

// File: tb/tb_cube_face_raster.sv
// Directed-vector bench for cube_face_raster (apex 400,200, default geometry).
module tb_cube_face_raster;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x_cnt, x_offset;
    logic [9:0]  y_cnt, y_offset;
    logic [3:0]  top_face;
    logic        left_face, right_face;
`ifdef QBERT_HIT_EN
    logic [10:0] qbert_x;
    logic [9:0]  qbert_y;
    logic        qbert_land;
    logic        cube_state;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cube_face_raster dut (
        .clk(clk),
        .reset(reset),
        .x_cnt(x_cnt),
        .y_cnt(y_cnt),
        .x_offset(x_offset),
        .y_offset(y_offset),
        .top_face(top_face),
        .left_face(left_face),
        .right_face(right_face)
`ifdef QBERT_HIT_EN
        ,
        .qbert_x(qbert_x),
        .qbert_y(qbert_y),
        .qbert_land(qbert_land),
        .cube_state(cube_state)
`endif
    );

    // Observed pixel word: {left, right, top[3:0]}
    logic [5:0] obs;
    assign obs = {left_face, right_face, top_face};

    task automatic check_vec(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int y);
        y_cnt = 10'(y);
        repeat (5) tick();
    endtask

    task automatic run_rows(input int from, input int to);
        for (int r = from; r <= to; r++) set_row(r);
    endtask

    task automatic pix(input int x, input logic [5:0] exp, input string tag);
        x_cnt = 11'(x);
        tick();
        check_vec(tag, obs, exp);
    endtask

    initial begin
        reset    = 1'b1;
        x_cnt    = '0;
        y_cnt    = 10'd5;
        x_offset = 11'd400;
        y_offset = 10'd200;
`ifdef QBERT_HIT_EN
        qbert_x    = '0;
        qbert_y    = '0;
        qbert_land = 1'b0;
`endif
        repeat (3) tick();
        check_vec("reset_out", obs, 6'b000000);
`ifdef QBERT_HIT_EN
        check_vec("reset_cube_state", {5'b0, cube_state}, 6'b000000);
`endif
        reset = 1'b0;
        repeat (3) tick();
        pix(400, 6'b000000, "idle_before_frame");

        run_rows(0, 200);
        pix(400, 6'b000001, "apex");
        pix(399, 6'b000000, "apex_left");

        run_rows(201, 245);
        pix(425, 6'b000001, "r245_ur_edge");
        pix(426, 6'b000000, "r245_ur_out");
        pix(375, 6'b000010, "r245_ul_edge");
        pix(374, 6'b000000, "r245_ul_out");

`ifdef QBERT_HIT_EN
        qbert_x = 11'd410; qbert_y = 10'd260; qbert_land = 1'b1;
        tick();
        qbert_land = 1'b0;
        check_vec("land_inside", {5'b0, cube_state}, 6'b000001);
        qbert_x = 11'd460; qbert_land = 1'b1;
        tick();
        qbert_land = 1'b0;
        check_vec("land_outside", {5'b0, cube_state}, 6'b000001);
        qbert_x = 11'd410; qbert_land = 1'b1;
        tick();
        qbert_land = 1'b0;
        check_vec("land_again", {5'b0, cube_state}, 6'b000000);
`endif

        run_rows(246, 290);
        pix(450, 6'b000101, "r290_right_tip");
        pix(350, 6'b001010, "r290_left_tip");
        pix(451, 6'b000000, "r290_out");

        run_rows(291, 300);
        x_offset = 11'd600;
        run_rows(301, 335);
        pix(360, 6'b100000, "r335_left");
        pix(375, 6'b001000, "r335_ll_masks_left");
        pix(440, 6'b010000, "r335_right");
        pix(451, 6'b000000, "r335_out");

        run_rows(0, 200);
        pix(600, 6'b000001, "f2_apex_moved");
        pix(400, 6'b000000, "f2_old_apex");
        pix(601, 6'b000000, "f2_apex_right");

        run_rows(201, 250);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pix(600, 6'b000000, "mid_reset_out");
        run_rows(251, 290);
        pix(650, 6'b000000, "post_reset_hold");

        run_rows(0, 290);
        pix(650, 6'b000101, "f3_right_tip");
        pix(550, 6'b001010, "f3_left_tip");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
